// File: rtl/fsm1_mem_resp.sv
// Memory-side responder for the go/rd/ws/ds read handshake: answers each rd
// request with a per-request number of ws cycles, then returns a word from a local array.
module fsm1_mem_resp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int WAIT_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              ws,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rerr,
    output logic              abort,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    // state | meaning
    // IDLE  | no request; accepts on rd=1
    // WAIT  | request accepted, ws high, wait counter running down
    // HOLD  | data presented, waiting for rd to drop
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                ws_nxt, rerr_nxt, abort_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                complete;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_oor;
    logic [DATA_W-1:0]   rd_word;

    // A zero-wait request completes on its accept edge, so it reads the live address.
    assign rd_addr = (state == IDLE) ? addr : addr_q;
    assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_L);
    assign rd_word = rd_oor ? '0 : mem[rd_addr];
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        ws_nxt    = ws;
        rdata_nxt = rdata;
        rerr_nxt  = 1'b0;
        abort_nxt = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                ws_nxt = 1'b0;
                if (rd) begin
                    addr_nxt = addr;
                    cnt_nxt  = wait_cfg;
                    if (wait_cfg != '0) begin
                        state_nxt = WAIT;
                        ws_nxt    = 1'b1;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!rd) begin
                    state_nxt = IDLE;
                    ws_nxt    = 1'b0;
                    abort_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == WAIT_W'(1)) begin
                        complete  = 1'b1;
                        ws_nxt    = 1'b0;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                ws_nxt = 1'b0;
                if (!rd) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ws_nxt    = 1'b0;
            end
        endcase
        if (complete) begin
            rdata_nxt = rd_word;
            rerr_nxt  = rd_oor;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            ws     <= 1'b0;
            rdata  <= '0;
            rerr   <= 1'b0;
            abort  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            ws     <= ws_nxt;
            rdata  <= rdata_nxt;
            rerr   <= rerr_nxt;
            abort  <= abort_nxt;
        end
    end

    // The read above samples mem before this edge's write lands, so a same-edge write returns the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && ({1'b0, waddr} < DEPTH_L)) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_fsm1_mem_resp.sv
// Scoreboard bench for fsm1_mem_resp: a DEPTH=16 and a DEPTH=12 instance share stimulus.
module tb_fsm1_mem_resp;

    logic       clock = 1'b0;
    logic       reset, rd, we;
    logic [3:0] addr, waddr;
    logic [2:0] wait_cfg;
    logic [7:0] wdata;
    logic       ws, busy, rerr, abort;
    logic [7:0] rdata;
    logic       ws12, busy12, rerr12, abort12;
    logic [7:0] rdata12;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] model_mem [16];
    logic [7:0] exp_q [$];

    always #5 clock = ~clock;

    fsm1_mem_resp #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_W(3)) dut (
        .clock(clock), .reset(reset), .rd(rd), .addr(addr), .wait_cfg(wait_cfg),
        .ws(ws), .rdata(rdata), .busy(busy), .rerr(rerr), .abort(abort),
        .we(we), .waddr(waddr), .wdata(wdata));

    fsm1_mem_resp #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_W(3)) dut12 (
        .clock(clock), .reset(reset), .rd(rd), .addr(addr), .wait_cfg(wait_cfg),
        .ws(ws12), .rdata(rdata12), .busy(busy12), .rerr(rerr12), .abort(abort12),
        .we(we), .waddr(waddr), .wdata(wdata));

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
        model_mem[a] = d;
    endtask

    // Full transaction against the DEPTH=16 instance: counts ws cycles, checks data and hold.
    task automatic do_read(input logic [3:0] a, input logic [2:0] wc, input string tag);
        int n = 0;
        logic [7:0] exp;
        exp_q.push_back(model_mem[a]);
        rd = 1'b1; addr = a; wait_cfg = wc;
        tick();
        addr = ~a; wait_cfg = ~wc;
        while (ws && n < 20) begin n++; tick(); end
        exp = exp_q.pop_front();
        total++; if (n !== int'(wc)) $display("FAIL %s ws_cycles got %0d want %0d", tag, n, wc); else passed++;
        total++; if (rdata !== exp) $display("FAIL %s rdata got %h want %h", tag, rdata, exp); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL %s busy_done got %b want 1", tag, busy); else passed++;
        tick();
        total++; if (ws !== 1'b0 || busy !== 1'b1 || rdata !== exp)
            $display("FAIL %s hold got ws=%b busy=%b rdata=%h want 0 1 %h", tag, ws, busy, rdata, exp); else passed++;
        rd = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || rdata !== exp)
            $display("FAIL %s release got busy=%b rdata=%h want 0 %h", tag, busy, rdata, exp); else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd = 1'b0; addr = '0; wait_cfg = '0;
        we = 1'b1; waddr = 4'd2; wdata = 8'hFF;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        tick(); tick();
        total++; if ({ws, busy, rerr, abort} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {ws, busy, rerr, abort}); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else passed++;
        reset = 1'b0; we = 1'b0;
        tick();
        do_read(4'd2, 3'd1, "reset_we_ignored");
    endtask

    task automatic test_zero_wait();
        wr(4'd3, 8'hA5);
        do_read(4'd3, 3'd0, "zero_wait");
    endtask

    task automatic test_read_fsm();
        typedef enum logic [1:0] {F_IDLE, F_READ, F_DELAY, F_DONE} fst_t;
        fst_t fst;
        logic [1:0] seq [$];
        logic [1:0] want [5];
        int nws = 0;
        int nds = 0;
        want[0] = F_READ; want[1] = F_DELAY; want[2] = F_READ; want[3] = F_DELAY; want[4] = F_DONE;
        wr(4'd5, 8'h3C);
        addr = 4'd5; wait_cfg = 3'd2;
        exp_q.push_back(model_mem[5]);
        fst = F_READ; rd = 1'b1; seq.push_back(fst);
        for (int i = 0; i < 20 && fst != F_IDLE; i++) begin
            tick();
            if (ws) nws++;
            case (fst)
                F_READ:  fst = F_DELAY;
                F_DELAY: fst = ws ? F_READ : F_DONE;
                default: fst = F_IDLE;
            endcase
            rd = (fst == F_READ) || (fst == F_DELAY);
            if (fst == F_DONE) begin
                logic [7:0] exp;
                nds++;
                exp = exp_q.pop_front();
                total++; if (rdata !== exp) $display("FAIL fsm_rdata got %h want %h", rdata, exp); else passed++;
            end
            if (fst != F_IDLE) seq.push_back(fst);
        end
        total++; if (nws !== 2) $display("FAIL fsm_ws_cycles got %0d want 2", nws); else passed++;
        total++; if (nds !== 1) $display("FAIL fsm_ds_count got %0d want 1", nds); else passed++;
        total++; if (seq.size() !== 5) $display("FAIL fsm_seq_len got %0d want 5", seq.size()); else passed++;
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            total++; if (seq[i] !== want[i]) $display("FAIL fsm_seq[%0d] got %0d want %0d", i, seq[i], want[i]); else passed++;
        end
        total++; if (busy !== 1'b0) $display("FAIL fsm_release busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_max_wait();
        wr(4'd0, 8'h5A);
        do_read(4'd0, 3'd7, "max_wait");
    endtask

    task automatic test_abort();
        rd = 1'b1; addr = 4'd7; wait_cfg = 3'd5;
        tick(); tick();
        total++; if (ws !== 1'b1) $display("FAIL abort_pre ws got %b want 1", ws); else passed++;
        rd = 1'b0;
        tick();
        total++; if ({abort, ws, busy} !== 3'b100)
            $display("FAIL abort_pulse got abort/ws/busy=%b want 100", {abort, ws, busy}); else passed++;
        total++; if (rdata !== 8'h5A) $display("FAIL abort_rdata got %h want 5a", rdata); else passed++;
        tick();
        total++; if (abort !== 1'b0) $display("FAIL abort_width got %b want 0", abort); else passed++;
    endtask

    task automatic test_out_of_range();
        int n = 0;
        wr(4'd13, 8'hEE);
        rd = 1'b1; addr = 4'd13; wait_cfg = 3'd1;
        tick();
        while (ws12 && n < 20) begin n++; tick(); end
        total++; if (n !== 1) $display("FAIL oor_ws_cycles got %0d want 1", n); else passed++;
        total++; if (rdata12 !== 8'h00) $display("FAIL oor_rdata got %h want 00", rdata12); else passed++;
        total++; if (rerr12 !== 1'b1) $display("FAIL oor_rerr got %b want 1", rerr12); else passed++;
        total++; if (rerr !== 1'b0 || rdata !== 8'hEE)
            $display("FAIL inrange16 got rerr=%b rdata=%h want 0 ee", rerr, rdata); else passed++;
        tick();
        total++; if (rerr12 !== 1'b0) $display("FAIL oor_rerr_width got %b want 0", rerr12); else passed++;
        rd = 1'b0;
        tick();
    endtask

    task automatic test_write_collision();
        wr(4'd4, 8'h99);
        exp_q.push_back(8'h11);
        rd = 1'b1; addr = 4'd4; wait_cfg = 3'd2;
        tick();
        we = 1'b1; waddr = 4'd4; wdata = 8'h11;
        tick();
        wdata = 8'h22;
        tick();
        we = 1'b0; model_mem[4] = 8'h22;
        begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            total++; if (rdata !== exp || ws !== 1'b0)
                $display("FAIL collision got rdata=%h ws=%b want %h 0", rdata, ws, exp); else passed++;
        end
        rd = 1'b0;
        tick();
        do_read(4'd4, 3'd0, "collision_after");
    endtask

    task automatic test_reset_mid_wait();
        rd = 1'b1; addr = 4'd5; wait_cfg = 3'd5;
        tick(); tick();
        reset = 1'b1;
        tick();
        total++; if ({ws, busy} !== 2'b00 || rdata !== 8'h00)
            $display("FAIL reset_mid got ws=%b busy=%b rdata=%h want 0 0 00", ws, busy, rdata); else passed++;
        reset = 1'b0; rd = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        tick();
        do_read(4'd3, 3'd0, "cleared_a3");
        do_read(4'd5, 3'd1, "cleared_a5");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_read_fsm();
        test_max_wait();
        test_abort();
        test_out_of_range();
        test_write_collision();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/fsm1_mem_resp.md
Name: fsm1_mem_resp

Overview:
- Memory-side responder for the go/rd/ws/ds read-handshake controller.
- The controller drives rd and samples ws. This block answers each rd request with a programmable number of wait-state cycles on ws, then presents read data from an internal register array.
- Sits between the read FSM and its data source. Also serves as the standard bench partner for that FSM.

Parameters:
- DATA_W, 8, width of read/write data
- ADDR_W, 4, width of address buses
- DEPTH, 16, number of array words (1..2**ADDR_W, need not be a power of two)
- WAIT_W, 3, width of the per-request wait-count input

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd  in  1  read request level from the initiator; held high for the whole transaction
- addr  in  ADDR_W  read address, sampled on request accept
- wait_cfg  in  WAIT_W  number of ws cycles for this request, sampled on accept
- ws  out  1  wait-state flag to the initiator; registered
- rdata  out  DATA_W  read data; registered, held between transactions
- busy  out  1  high while a request is accepted and not yet released
- rerr  out  1  one-cycle pulse: out-of-range address completed
- abort  out  1  one-cycle pulse: rd dropped before completion
- we  in  1  array write enable (load port)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - state = IDLE.
  - ws, busy, rerr and abort = 0.
  - rdata = 0, wait counter = 0.
  - All array words = 0. A we asserted in the same cycle as reset is ignored.
- States are IDLE, WAIT, HOLD. busy = (state != IDLE).
- IDLE:
  - On rd=1, latch addr and load cnt = wait_cfg.
  - If wait_cfg != 0: go to WAIT, ws <= 1.
  - If wait_cfg == 0: complete immediately (see completion) and go to HOLD, ws stays 0.
- WAIT:
  - ws = 1. cnt decrements each cycle.
  - On the edge where cnt goes 1 -> 0: complete, ws <= 0, go to HOLD.
  - ws is therefore high for exactly wait_cfg cycles, starting the cycle after accept.
- Completion edge:
  - rdata <= array[latched addr].
  - If latched addr >= DEPTH: rdata <= 0 and rerr pulses for the following cycle.
- HOLD:
  - ws = 0, rdata stable.
  - Remain in HOLD while rd=1. On rd=0, go to IDLE.
  - A new request is accepted only after rd has been seen low at least one cycle; no back-to-back accept without a gap.
- Abort:
  - rd=0 while in WAIT -> IDLE next edge, ws <= 0, abort pulses one cycle.
  - rdata is unchanged and no array read occurs.
- Write port:
  - Active in any state. array[waddr] <= wdata when we=1 and waddr < DEPTH.
  - Out-of-range writes are dropped silently.
  - A write to the latched address on the completion edge returns the OLD value; any earlier write is visible.
- Changes to addr or wait_cfg after accept have no effect on the current transaction.
- Latency: from rd rising to rdata valid and ws low = wait_cfg+1 edges; a wait_cfg of 0 gives 1 edge.

Test Plan:
- Reset, then write array[3]=8'hA5; rd=1, addr=3, wait_cfg=0 -> ws never high, busy=1 next cycle, rdata=8'hA5 one edge after accept; rd=0 -> busy=0.
- Connect the go/rd/ws/ds read FSM, wait_cfg=2, array[5]=8'h3C, pulse go -> ws high 2 cycles, FSM cycles READ/DELAY/READ/DELAY/DONE, ds=1 exactly once, rdata=8'h3C at DONE.
- wait_cfg=7 (max), addr=0 -> ws high exactly 7 consecutive cycles, then rdata=array[0] and ws=0.
- rd dropped after 2 of 5 wait cycles -> abort=1 for one cycle, ws=0, busy=0, rdata keeps previous value.
- DEPTH=12, addr=13, wait_cfg=1 -> ws high 1 cycle, rdata=0, rerr=1 for one cycle.
- Write array[4]=8'h11 during WAIT and then 8'h22 on the completion edge -> rdata=8'h11.
- Assert reset mid-WAIT -> ws=0, busy=0, rdata=0 next edge; array reads back 0.
